alu_front_pipe: RTL and testbench
=================================

Name: alu_front_pipe

Overview:
- Parametrised, pipelined successor to the combinational ALU operand front-end.
- Selects and conditions the two ALU operands from aluop/func/shamt/op1/op2, and adds a configurable datapath width.
- Adds a STAGES-deep register pipeline with a valid/ready handshake, a synchronous flush and decode side-flags.
- Sits between register-read and the ALU core.

Parameters:
WIDTH, 32, datapath width; power of two, 8..64
STAGES, 2, pipeline depth in registers, 1..4
RTYPE_OP, 5'b01001, aluop value meaning "decode func field"

Ports:
clk  input  1  clock, rising-edge
rst_n  input  1  synchronous active-low reset
flush  input  1  synchronous pipeline clear
in_valid  input  1  input transaction present
in_ready  output  1  input accepted when in_valid && in_ready
aluop  input  5  decoder ALU op class
func  input  6  R-type func field
shamt  input  5  instruction shift amount
op1  input  WIDTH  rs value
op2  input  WIDTH  rt value or immediate
out_valid  output  1  output transaction present
out_ready  input  1  downstream accepts when out_valid && out_ready
out_1  output  WIDTH  ALU operand A
out_2  output  WIDTH  ALU operand B
out_shift  output  1  operation is a shift
out_arith  output  1  arithmetic (sign-filling) shift

Behaviour:
- Clock and reset: one clock, clk. rst_n is synchronous and active-low, sampled on the rising clk edge.
- Reset (rst_n=0 at an edge): all stage valid bits and data registers clear to 0. out_valid=0, out_1=0, out_2=0, out_shift=0, out_arith=0.
  - Reset mid-operation discards all in-flight transactions.
  - Reset has priority over flush and over the handshake.
- Decode (combinational, applied at the input before stage 1). When aluop==RTYPE_OP:
  - func 0x00/0x02/0x03 (sll/srl/sra): out_1=op2; out_2=zero-extended shamt; shift=1; arith=(func==0x03).
  - func 0x04/0x06/0x07 (sllv/srlv/srav): out_1=op2; out_2=zero-extended op1[log2(WIDTH)-1:0]; shift=1; arith=(func==0x07).
  - Any other func (including mult/div 0x18..0x1B): out_1=op1; out_2=op2; shift=0; arith=0.
- Decode when aluop!=RTYPE_OP: pass-through, out_1=op1, out_2=op2, flags 0.
- Pipeline advance:
  - advance = !out_valid || out_ready.
  - All stages shift together on advance; nothing moves when advance=0.
  - Bubbles are not collapsed.
- Input handshake:
  - in_ready = advance && !flush.
  - An accepted transaction enters stage 1 with valid=1.
  - On advance with no accepted input, stage 1 loads valid=0.
- Latency: exactly STAGES cycles from acceptance to out_valid, with no backpressure. Throughput is one transaction per cycle.
- Backpressure: while out_valid=1 && out_ready=0:
  - out_1, out_2, flags and out_valid stay stable.
  - in_ready=0.
- Flush (flush=1, rst_n=1): all valid bits clear at the edge; the input is not accepted that cycle. Data registers may hold stale values; only valid is specified.
- Simultaneous flush and out_ready: the output handshake completes this cycle, then the pipe is empty.
- No wrap-around state; there is no other internal state.

Test Plan:
- Reset/idle: rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, out_1=out_2=0, in_ready irrelevant. After release, the first accepted input appears STAGES cycles later.
- SRA decode, WIDTH=32, STAGES=2, out_ready=1: aluop=5'b01001, func=3, shamt=5, op1=17, op2=-65535 -> 2 cycles later out_valid=1, out_1=32'hFFFF0001, out_2=5, out_shift=1, out_arith=1.
- MULT pass-through: same operands, func=0x18 -> out_1=17, out_2=32'hFFFF0001, out_shift=0. Back-to-back with the previous test -> consecutive cycles at the output.
- Variable shift, WIDTH=64: func=0x04, op1=64'h00000000000000E3, op2=1 -> out_1=1, out_2=35 (6-bit mask), out_arith=0.
- Backpressure: stream 4 transactions (op1=1..4), hold out_ready=0 for 3 cycles after the first out_valid -> output stays op1=1, in_ready=0. Release -> 1,2,3,4 delivered in order, none lost or duplicated.
- Flush / reset mid-flight: 2 transactions in flight, pulse flush for 1 cycle -> out_valid never rises for either, and the next input delivers normally. Repeat with rst_n=0 instead of flush -> same result and all outputs 0.

Source files
------------

// File: rtl/alu_front_pipe.sv
// ALU operand front-end: decodes shift/pass-through operand selection, then carries
// the result through a STAGES-deep valid/ready pipeline with flush.
module alu_front_pipe #(
    parameter int          WIDTH    = 32,
    parameter int          STAGES   = 2,
    parameter logic [4:0]  RTYPE_OP = 5'b01001
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       aluop,
    input  logic [5:0]       func,
    input  logic [4:0]       shamt,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_1,
    output logic [WIDTH-1:0] out_2,
    output logic             out_shift,
    output logic             out_arith
);
    localparam int SW = $clog2(WIDTH);
    localparam int DW = 2 * WIDTH + 2;

    logic [WIDTH-1:0] dec_1;
    logic [WIDTH-1:0] dec_2;
    logic             dec_shift;
    logic             dec_arith;
    logic [DW-1:0]    stage_data [STAGES];
    logic [STAGES-1:0] stage_vld;
    logic             advance;

    always_comb begin
        dec_1     = op1;
        dec_2     = op2;
        dec_shift = 1'b0;
        dec_arith = 1'b0;
        if (aluop == RTYPE_OP) begin
            case (func)
                6'h00, 6'h02, 6'h03: begin
                    dec_1     = op2;
                    dec_2     = {{(WIDTH-5){1'b0}}, shamt};
                    dec_shift = 1'b1;
                    dec_arith = (func == 6'h03);
                end
                // Variable shifts take the amount from rs, masked to the datapath width.
                6'h04, 6'h06, 6'h07: begin
                    dec_1     = op2;
                    dec_2     = {{(WIDTH-SW){1'b0}}, op1[SW-1:0]};
                    dec_shift = 1'b1;
                    dec_arith = (func == 6'h07);
                end
                default: begin
                    dec_1     = op1;
                    dec_2     = op2;
                    dec_shift = 1'b0;
                    dec_arith = 1'b0;
                end
            endcase
        end
    end

    assign advance  = !stage_vld[STAGES-1] || out_ready;
    assign in_ready = advance && !flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_vld <= '0;
            for (int i = 0; i < STAGES; i++) stage_data[i] <= '0;
        end else begin
            if (flush) begin
                stage_vld <= '0;
            end else if (advance) begin
                stage_vld[0] <= in_valid;
                for (int i = 1; i < STAGES; i++) stage_vld[i] <= stage_vld[i-1];
            end
            // Data follows advance even on flush; only valid bits carry meaning.
            if (advance) begin
                stage_data[0] <= {dec_shift, dec_arith, dec_2, dec_1};
                for (int i = 1; i < STAGES; i++) stage_data[i] <= stage_data[i-1];
            end
        end
    end

    assign out_valid = stage_vld[STAGES-1];
    assign {out_shift, out_arith, out_2, out_1} = stage_data[STAGES-1];
endmodule

// File: tb/tb_alu_front_pipe.sv
// Scoreboard bench: a 32-bit and a 64-bit instance share control; expected operands
// are computed by a bench-side decode model when each input is accepted.
module tb_alu_front_pipe;
    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [4:0]  aluop, shamt;
    logic [5:0]  func;
    logic [63:0] op1_w, op2_w;
    logic        in_ready_n, out_valid_n, shift_n, arith_n;
    logic [31:0] out_1_n, out_2_n;
    logic        in_ready_w, out_valid_w, shift_w, arith_w;
    logic [63:0] out_1_w, out_2_w;

    typedef struct {
        logic [31:0] o1n, o2n;
        logic [63:0] o1w, o2w;
        logic        sh, ar;
    } exp_t;

    exp_t q[$];
    int n_chk = 0;
    int n_err = 0;
    bit rnd_done;

    always #5 clk = ~clk;

    alu_front_pipe #(.WIDTH(32), .STAGES(2)) dut_n (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_n),
        .aluop(aluop), .func(func), .shamt(shamt), .op1(op1_w[31:0]), .op2(op2_w[31:0]),
        .out_valid(out_valid_n), .out_ready(out_ready), .out_1(out_1_n), .out_2(out_2_n),
        .out_shift(shift_n), .out_arith(arith_n));

    alu_front_pipe #(.WIDTH(64), .STAGES(2)) dut_w (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_w),
        .aluop(aluop), .func(func), .shamt(shamt), .op1(op1_w), .op2(op2_w),
        .out_valid(out_valid_w), .out_ready(out_ready), .out_1(out_1_w), .out_2(out_2_w),
        .out_shift(shift_w), .out_arith(arith_w));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [4:0] a_op, input logic [5:0] f, input logic [4:0] s,
                                  input logic [63:0] a, input logic [63:0] b, input int w,
                                  output logic [63:0] o1, output logic [63:0] o2,
                                  output logic sh, output logic ar);
        logic [63:0] mask;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        a = a & mask;
        b = b & mask;
        o1 = a; o2 = b; sh = 1'b0; ar = 1'b0;
        if (a_op == 5'b01001) begin
            if (f == 6'd0 || f == 6'd2 || f == 6'd3) begin
                o1 = b; o2 = 64'(s); sh = 1'b1; ar = (f == 6'd3);
            end else if (f == 6'd4 || f == 6'd6 || f == 6'd7) begin
                o1 = b; o2 = a % 64'(w); sh = 1'b1; ar = (f == 6'd7);
            end
        end
    endfunction

    function automatic exp_t make_exp();
        exp_t e;
        logic [63:0] o1, o2;
        logic sh, ar, sh2, ar2;
        model(aluop, func, shamt, op1_w, op2_w, 32, o1, o2, sh, ar);
        e.o1n = o1[31:0]; e.o2n = o2[31:0]; e.sh = sh; e.ar = ar;
        model(aluop, func, shamt, op1_w, op2_w, 64, o1, o2, sh2, ar2);
        e.o1w = o1; e.o2w = o2;
        return e;
    endfunction

    // Monitor sits on the falling edge, where inputs and outputs are stable.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q.delete();
        end else begin
            if (out_valid_n && out_ready) begin
                if (q.size() == 0) begin
                    check("spurious_out", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("out_1_n", 64'(out_1_n), 64'(e.o1n));
                    check("out_2_n", 64'(out_2_n), 64'(e.o2n));
                    check("flags_n", {62'd0, shift_n, arith_n}, {62'd0, e.sh, e.ar});
                    check("valid_w", 64'(out_valid_w), 64'd1);
                    check("out_1_w", out_1_w, e.o1w);
                    check("out_2_w", out_2_w, e.o2w);
                    check("flags_w", {62'd0, shift_w, arith_w}, {62'd0, e.sh, e.ar});
                end
            end else if (q.size() == 0) begin
                check("idle_valid", 64'(out_valid_n), 64'd0);
            end
            if (flush) q.delete();
            else if (in_valid && in_ready_n) q.push_back(make_exp());
        end
    end

    task automatic send(input logic [4:0] a_op, input logic [5:0] f, input logic [4:0] s,
                        input logic [63:0] a, input logic [63:0] b);
        bit acc;
        aluop = a_op; func = f; shamt = s; op1_w = a; op2_w = b; in_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready_n;
            @(posedge clk);
            #1;
        end
        if (!acc) check("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((q.size() != 0 || out_valid_n) && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 50) check("drain_timeout", 0, 1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, {62'd0, out_valid_n, out_valid_w}, 64'd0);
        check({tag, "_o1"}, out_1_w | 64'(out_1_n), 64'd0);
        check({tag, "_o2"}, out_2_w | 64'(out_2_n), 64'd0);
        check({tag, "_flags"}, {60'd0, shift_n, arith_n, shift_w, arith_w}, 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        aluop = 5'b01001; func = 6'd3; shamt = 5'd7; op1_w = 64'd9; op2_w = 64'd9;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        in_valid = 1'b0;
        rst_n = 1'b1;

        // SRA then MULT back-to-back; checks latency and consecutive delivery.
        send(5'b01001, 6'h03, 5'd5, 64'd17, -64'sd65535);
        check("lat_first_edge", 64'(out_valid_n), 64'd0);
        send(5'b01001, 6'h18, 5'd5, 64'd17, -64'sd65535);
        check("lat_second_edge", 64'(out_valid_n), 64'd1);
        check("sra_out_1", 64'(out_1_n), 64'hFFFF0001);
        @(posedge clk);
        #1;
        check("b2b_valid", 64'(out_valid_n), 64'd1);
        check("mult_out_2", 64'(out_2_n), 64'hFFFF0001);
        drain();

        // sllv: amount masked to 5 bits (3) vs 6 bits (35).
        send(5'b01001, 6'h04, 5'd0, 64'hE3, 64'd1);
        @(posedge clk);
        #1;
        check("sllv_o2_n", 64'(out_2_n), 64'd3);
        check("sllv_o2_w", out_2_w, 64'd35);
        drain();

        // Backpressure: stall 3 cycles once the first result shows.
        fork
            for (int i = 1; i <= 4; i++) send(5'b00000, 6'h00, 5'd0, 64'(i), 64'(10 + i));
            begin
                int k;
                k = 0;
                while (!out_valid_n && k < 20) begin
                    @(posedge clk);
                    #1;
                    k++;
                end
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("bp_hold_valid", 64'(out_valid_n), 64'd1);
                    check("bp_hold_o1", 64'(out_1_n), 64'd1);
                    check("bp_in_ready", 64'(in_ready_n), 64'd0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Flush and then reset with two transactions in flight.
        for (int pass = 0; pass < 2; pass++) begin
            out_ready = 1'b0;
            send(5'b00000, 6'h00, 5'd0, 64'd5, 64'd6);
            send(5'b01001, 6'h02, 5'd4, 64'd7, 64'd8);
            in_valid = 1'b1;
            if (pass == 0) flush = 1'b1;
            else rst_n = 1'b0;
            @(posedge clk);
            #1;
            flush = 1'b0; rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
            if (pass == 0) check("flush_clear", 64'(out_valid_n), 64'd0);
            else check_zero("mid_reset");
            repeat (3) @(posedge clk);
            #1;
            send(5'b01001, 6'h07, 5'd0, 64'h21, 64'h8000_0000);
            drain();
        end

        // Random mix with random downstream stalls.
        rnd_done = 1'b0;
        fork
            begin
                logic [5:0] funcs [10];
                funcs = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h18, 6'h1B, 6'h20, 6'h2A};
                for (int i = 0; i < 24; i++)
                    send(($urandom_range(0, 3) != 0) ? 5'b01001 : 5'($urandom),
                         funcs[$urandom_range(0, 9)], 5'($urandom),
                         {$urandom, $urandom}, {$urandom, $urandom});
                rnd_done = 1'b1;
            end
            while (!rnd_done) begin
                @(posedge clk);
                #1;
                out_ready = ($urandom_range(0, 2) != 0);
            end
        join
        out_ready = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
